alu: RTL and testbench
======================

Name: alu

Overview:
- Registered 32-bit ALU with four opcodes: add, logical shift left, parity, and an undefined opcode that returns zero.
- Operands A/B and opcode OPC are sampled when in_valid is high; result R is presented one clock later with out_valid.
- Used as a leaf datapath block; no back-pressure.

Parameters:
- WIDTH, 32, operand and result width in bits (all values below assume 32).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/opcode qualifier; sample A, B, OPC this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned; shift amount for OPC=01.
- OPC  input  2  operation select.
- R  output  WIDTH  registered result.
- out_valid  output  1  high for one cycle when R holds a new result.

Behaviour:
- Reset:
  - rst_n low immediately forces R=0 and out_valid=0, independent of clk.
  - Both stay 0 until the first rising edge after rst_n deasserts.
  - Asserting reset mid-operation discards any pending result; no out_valid pulse follows.
- Latency and handshake:
  - A rising edge with in_valid=1 loads R with f(A,B,OPC) and sets out_valid=1 on the following cycle.
  - Fixed latency of 1 cycle; throughput of 1 operation per cycle.
  - Back-to-back valid inputs produce back-to-back results.
  - A rising edge with in_valid=0 holds R at its previous value and drives out_valid=0.
  - Inputs are don't-care when in_valid=0.
- OPC=00, add:
  - R = (A + B) mod 2^32.
  - Carry out is discarded; no flags.
- OPC=01, logical shift left:
  - R = A shifted left by the full unsigned value of B, zero-filled from the LSB.
  - B=0 gives R=A.
  - Any B >= 32 gives R=0; the shift amount is not truncated to 5 bits.
- OPC=10, parity:
  - R[0] = XOR reduction of all 32 bits of A (1 when A has an odd number of ones).
  - R[31:1] = 0.
  - B is ignored.
- OPC=11, undefined:
  - R = 0 regardless of A and B.
- Result logic:
  - Purely combinational from the sampled inputs into the R register.
  - No internal state other than R and out_valid.
- X/Z handling:
  - An OPC containing X or Z produces R=0 (default branch).

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with R nonzero -> R=0 and out_valid=0 immediately. Release rst_n, then idle -> R stays 0.
- Add: A=3,B=5 -> R=8. A=399,B=21 -> R=420. A=0xFFFFFFFF,B=1 -> R=0 (wrap). A=1,B=1 -> R=2. Each result appears one cycle after the in_valid edge, with out_valid=1.
- Shift left:
  - A=0x00000FFF, B=1 -> R=0x00001FFE.
  - A=0, B=5 -> R=0.
  - A=0xF, B=2 -> R=0x3C.
  - A=0xF, B=0 -> R=0xF.
  - A=0xF, B=3 -> R=0x78.
  - A=0xFFFFFFFF, B=20 -> R=0xFFF00000.
  - A=0xFFFFFFFF, B=32 -> R=0.
- Parity (B=5 for all cases):
  - A=0x00000001 -> R=1.
  - A=0x00000000 -> R=0.
  - A=0xFFFFFFFF -> R=0.
  - A=0xFFFEFFFF -> R=1.
  - A=0x00FF01FF -> R=1.
- Undefined: OPC=11, A=4815, B=162342 -> R=0.
- Handshake:
  - Three back-to-back valid adds (1+1, 2+2, 3+3) -> R=2, 4, 6 on consecutive cycles with out_valid held high.
  - Then in_valid=0 with new A/B -> R holds 6 and out_valid=0.

Source files
------------

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- registered ALU with four opcodes.
//
// Operands and opcode are sampled on a rising edge with in_valid high. The
// result is loaded into R on that edge, and out_valid pulses for the following
// cycle. When in_valid is low, R holds its value and out_valid returns to 0.
//
//   OPC = 00 : R = A + B (mod 2^WIDTH), carry discarded
//   OPC = 01 : R = A << B, using the full value of B; B >= WIDTH gives 0
//   OPC = 10 : R = {0..., ^A}  (odd parity of A in bit 0)
//   OPC = 11 : R = 0
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears R and out_valid)
//   in_valid   qualifies A, B, OPC for this cycle
//   A, B       unsigned operands (B is the shift amount for OPC = 01)
//   OPC        operation select
//   R          registered result
//   out_valid  one-cycle pulse marking a new result in R
// -----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       OPC,
  output logic [WIDTH-1:0] R,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SHL = 2'b01,
    OP_PAR = 2'b10,
    OP_UND = 2'b11
  } op_e;

  localparam int               SHIFT_BITS = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V    = WIDTH'(WIDTH);

  logic [WIDTH-1:0] r_q, r_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result;

  // Result of the selected operation on the current inputs.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    result = '0;
    case (op_e'(OPC))
      OP_ADD: result = A + B;
      OP_SHL: begin
        // The whole of B counts as the shift amount: anything at or above
        // WIDTH clears the result, rather than wrapping on the low bits.
        if (B >= WIDTH_V) result = '0;
        else              result = A << B[SHIFT_BITS-1:0];
      end
      OP_PAR: result[0] = ^A;
      OP_UND: result = '0;
      // An opcode containing X/Z matches none of the above and yields 0.
      default: result = '0;
    endcase
  end

  // Next-state selection: load on valid, otherwise hold R and drop valid.
  always_comb begin
    r_d         = r_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      r_d         = result;
      out_valid_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so that every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign R         = r_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
//
// A behavioural model predicts R/out_valid from arithmetic on the sampled
// operands; a compare process checks the DUT against it on every falling edge.
// Directed cases from the test plan pin both the DUT and the model to literal
// expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   opc = 2'b00;
  logic [W-1:0] r;
  logic         out_valid;

  int n_total = 0;
  int n_pass  = 0;
  bit check_en = 1'b0;

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .OPC       (opc),
    .R         (r),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference function: plain arithmetic on the operands.
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] ref_f(input logic [W-1:0] fa,
                                         input logic [W-1:0] fb,
                                         input logic [1:0]   fopc);
    logic [63:0] wide;
    int          ones;
    case (fopc)
      2'b00: begin
        wide = 64'(fa) + 64'(fb);
        return wide[W-1:0];
      end
      2'b01: begin
        if (fb >= 32'd32) return '0;
        // Multiply by 2^B and keep the low 32 bits.
        wide = 64'(fa) * (64'd1 << fb);
        return wide[W-1:0];
      end
      2'b10: begin
        ones = 0;
        for (int i = 0; i < W; i++) if (fa[i]) ones++;
        return W'(ones % 2);
      end
      default: return '0;
    endcase
  endfunction

  // Expected registered outputs.
  logic [W-1:0] exp_r = '0;
  logic         exp_v = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r <= '0;
      exp_v <= 1'b0;
    end else if (in_valid) begin
      exp_r <= ref_f(a, b, opc);
      exp_v <= 1'b1;
    end else begin
      exp_v <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_out_valid", W'(out_valid), W'(exp_v));
      check("model_r", r, exp_r);
    end
  end

  // Drive one operation (caller sits just after a rising edge), let it be
  // sampled, then check the literal result and the model's agreement.
  task automatic op(input string name, input logic [W-1:0] ta,
                    input logic [W-1:0] tb, input logic [1:0] topc,
                    input logic [W-1:0] req);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    opc      = topc;
    @(posedge clk);
    #2;
    check(name, r, req);
    check({name, "_valid"}, W'(out_valid), W'(1));
    check({name, "_model"}, ref_f(ta, tb, topc), req);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    opc      = 2'($urandom);
    @(posedge clk);
    #2;
  endtask

  initial begin
    // ---------------- reset ----------------
    #2;
    check("reset_r", r, '0);
    check("reset_valid", W'(out_valid), W'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    check_en = 1'b1;
    idle();
    check("post_reset_idle_r", r, '0);

    // ---------------- add ----------------
    op("add_3_5",     32'd3,          32'd5,  2'b00, 32'd8);
    op("add_399_21",  32'd399,        32'd21, 2'b00, 32'd420);
    op("add_wrap",    32'hFFFF_FFFF,  32'd1,  2'b00, 32'd0);
    op("add_1_1",     32'd1,          32'd1,  2'b00, 32'd2);

    // ---------------- shift left ----------------
    op("shl_fff_1",   32'h0000_0FFF,  32'd1,  2'b01, 32'h0000_1FFE);
    op("shl_0_5",     32'h0,          32'd5,  2'b01, 32'h0);
    op("shl_f_2",     32'hF,          32'd2,  2'b01, 32'h3C);
    op("shl_f_0",     32'hF,          32'd0,  2'b01, 32'hF);
    op("shl_f_3",     32'hF,          32'd3,  2'b01, 32'h78);
    op("shl_ones_20", 32'hFFFF_FFFF,  32'd20, 2'b01, 32'hFFF0_0000);
    op("shl_ones_32", 32'hFFFF_FFFF,  32'd32, 2'b01, 32'h0);
    op("shl_big_b",   32'hFFFF_FFFF,  32'h0000_0101, 2'b01, 32'h0);

    // ---------------- parity ----------------
    op("par_1",        32'h0000_0001, 32'd5, 2'b10, 32'd1);
    op("par_0",        32'h0000_0000, 32'd5, 2'b10, 32'd0);
    op("par_ones",     32'hFFFF_FFFF, 32'd5, 2'b10, 32'd0);
    op("par_fffeffff", 32'hFFFE_FFFF, 32'd5, 2'b10, 32'd1);
    op("par_00ff01ff", 32'h00FF_01FF, 32'd5, 2'b10, 32'd1);

    // ---------------- undefined ----------------
    op("undef", 32'd4815, 32'd162342, 2'b11, 32'd0);

    // ---------------- handshake ----------------
    op("b2b_1", 32'd1, 32'd1, 2'b00, 32'd2);
    op("b2b_2", 32'd2, 32'd2, 2'b00, 32'd4);
    op("b2b_3", 32'd3, 32'd3, 2'b00, 32'd6);
    in_valid = 1'b0;
    a        = 32'd100;
    b        = 32'd200;
    @(posedge clk);
    #2;
    check("hold_r", r, 32'd6);
    check("hold_valid", W'(out_valid), W'(0));

    // ---------------- async reset mid-operation ----------------
    op("pre_reset_add", 32'd5, 32'd6, 2'b00, 32'd11);
    in_valid = 1'b1;            // pending operation, about to be discarded
    a        = 32'd7;
    b        = 32'd7;
    opc      = 2'b00;
    #1;
    rst_n = 1'b0;               // mid-cycle, no clock edge
    #1;
    check("async_reset_r", r, '0);
    check("async_reset_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #2;
    check("reset_held_r", r, '0);
    check("reset_held_valid", W'(out_valid), W'(0));
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("release_idle_r", r, '0);
      check("release_idle_valid", W'(out_valid), W'(0));
    end

    // ---------------- randomized ----------------
    for (int i = 0; i < 2000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a        = $urandom;
      case ($urandom_range(0, 2))
        0:       b = $urandom_range(0, 40);
        1:       b = $urandom;
        default: b = {$urandom_range(0, 1) ? 27'h0 : 27'($urandom), 5'($urandom)};
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      opc = 2'($urandom);
      @(posedge clk);
      #2;
    end
    idle();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
